align_shift_grs: RTL and testbench

Iterative right-shift aligner for the FP adder exponent-alignment stage. It accepts the smaller operand's mantissa plus the exponent difference, shifts right by STEP bits per clock, and returns the aligned mantissa with guard, round and sticky bits and the sign passed through. It generalises the earlier single-cycle sticky shifter in three ways: parametrised width, multi-cycle shifting, and GRS output with a valid/ready handshake on both sides.

---
 rtl/fp_align_pkg.sv | 20 ++
 rtl/grs_step_shift.sv | 22 ++
 rtl/align_shift_grs.sv | 138 +++++++++++++
 tb/tb_align_shift_grs.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/fp_align_pkg.sv
// Shared definitions for the exponent-alignment shifter: FSM state codes,
// GRS bit positions and the worst-case latency helper.
package fp_align_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t SHIFT = 2'd1;
    localparam state_t DONE  = 2'd2;

    localparam int GRS_G = 2;
    localparam int GRS_R = 1;
    localparam int GRS_S = 0;

    // Accept edge plus one edge per STEP-sized chunk of a fully saturated shift.
    function automatic int worst_latency(input int mant_w, input int step);
        return 1 + (mant_w + 2 + step - 1) / step;
    endfunction

endpackage

// File: rtl/grs_step_shift.sv
// Combinational right shift by 0..STEP bits; sticky_o is the OR of the bits
// that fall off the bottom.
module grs_step_shift #(
    parameter int W_W = 26,
    parameter int K_W = 3
) (
    input  logic [W_W-1:0] w_i,
    input  logic [K_W-1:0] k_i,
    output logic [W_W-1:0] w_o,
    output logic           sticky_o
);

    logic [W_W-1:0] mask_s;

    // Shift and collect the discarded low bits.
    always_comb begin
        mask_s   = ~({W_W{1'b1}} << k_i);
        w_o      = w_i >> k_i;
        sticky_o = |(w_i & mask_s);
    end

endmodule

// File: rtl/align_shift_grs.sv
// Iterative right-shift aligner producing mantissa plus {guard, round, sticky}.
// Define ALIGN_SATURATE_EN to finish over-range shifts in a single cycle.
module align_shift_grs
    import fp_align_pkg::*;
#(
    parameter int MANT_W  = 24,
    parameter int SHAMT_W = 8,
    parameter int STEP    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_sign,
    input  logic [MANT_W-1:0]  in_mant,
    input  logic [SHAMT_W-1:0] in_shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_sign,
    output logic [MANT_W-1:0]  out_mant,
    output logic [2:0]         out_grs
);

    localparam int W_W   = MANT_W + 2;
    localparam int REM_W = $clog2(W_W + 1);
    localparam int K_W   = $clog2(STEP + 1);
    localparam logic [REM_W-1:0] STEP_R = REM_W'(STEP);

    state_t            state_q, state_d;
    logic [W_W-1:0]    w_q, w_d;
    logic              s_q, s_d;
    logic              sign_q, sign_d;
    logic [REM_W-1:0]  rem_q, rem_d;

    logic [K_W-1:0]    k_s;
    logic [W_W-1:0]    sh_w_s;
    logic              sh_sticky_s;
    logic              sat_s;
    logic [REM_W-1:0]  rem_load_s;

    grs_step_shift #(
        .W_W (W_W),
        .K_W (K_W)
    ) u_step (
        .w_i      (w_q),
        .k_i      (k_s),
        .w_o      (sh_w_s),
        .sticky_o (sh_sticky_s)
    );

    // Per-cycle shift amount and saturated initial remainder.
    always_comb begin
        k_s        = (rem_q < STEP_R) ? rem_q[K_W-1:0] : K_W'(STEP);
        sat_s      = (32'(in_shamt) >= 32'(W_W));
        rem_load_s = sat_s ? REM_W'(W_W) : REM_W'(in_shamt);
    end

    // Next-state logic for the accept / shift / hold sequence.
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        s_d     = s_q;
        sign_d  = sign_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d = in_sign;
                    w_d    = {in_mant, 2'b00};
                    s_d    = 1'b0;
                    rem_d  = rem_load_s;
                    state_d = (rem_load_s == '0) ? DONE : SHIFT;
`ifdef ALIGN_SATURATE_EN
                    if (sat_s) begin
                        w_d     = '0;
                        s_d     = |in_mant;
                        rem_d   = '0;
                        state_d = DONE;
                    end else begin
                        state_d = (rem_load_s == '0) ? DONE : SHIFT;
                    end
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                w_d   = sh_w_s;
                s_d   = s_q | sh_sticky_s;
                rem_d = rem_q - REM_W'(k_s);
                if (rem_q == REM_W'(k_s)) begin
                    state_d = DONE;
                end else begin
                    state_d = SHIFT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset that aborts any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            w_q     <= '0;
            s_q     <= 1'b0;
            sign_q  <= 1'b0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            s_q     <= s_d;
            sign_q  <= sign_d;
            rem_q   <= rem_d;
        end
    end

    // Outputs decode directly from registers, so they are glitch-free and hold under backpressure.
    always_comb begin
        in_ready         = (state_q == IDLE);
        out_valid        = (state_q == DONE);
        out_sign         = sign_q;
        out_mant         = w_q[W_W-1:2];
        out_grs[GRS_G]   = w_q[1];
        out_grs[GRS_R]   = w_q[0];
        out_grs[GRS_S]   = s_q;
    end

endmodule

// File: tb/tb_align_shift_grs.sv
// Directed self-checking bench for align_shift_grs with default parameters.
module tb_align_shift_grs;
    import fp_align_pkg::*;

    localparam int LAT_MAX = worst_latency(24, 4);
`ifdef ALIGN_SATURATE_EN
    localparam int SAT_LAT = 1;
`else
    localparam int SAT_LAT = 8;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [23:0] in_mant;
    logic [7:0]  in_shamt;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic [23:0] out_mant;
    logic [2:0]  out_grs;

    int total = 0;
    int bad   = 0;

    align_shift_grs dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_mant   (in_mant),
        .in_shamt  (in_shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_mant  (out_mant),
        .out_grs   (out_grs)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one operand, wait for out_valid, check result and latency (accept edge = 1).
    task automatic do_op(input string tag, input logic [23:0] m, input logic [7:0] sh,
                         input logic sg, input logic [23:0] exp_m, input logic [2:0] exp_grs,
                         input int exp_lat);
        int lat;
        @(negedge clk);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_mant  = m;
        in_shamt = sh;
        in_sign  = sg;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < LAT_MAX + 4) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, ".lat"},  32'(lat),      32'(exp_lat));
        chk({tag, ".mant"}, 32'(out_mant), 32'(exp_m));
        chk({tag, ".grs"},  32'(out_grs),  32'(exp_grs));
        chk({tag, ".sign"}, 32'(out_sign), 32'(sg));
        chk({tag, ".busy"}, 32'(in_ready), 32'd0);
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, ".rel_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".rel_ready"}, 32'(in_ready),  32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_mant   = 24'h0;
        in_shamt  = 8'd0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.in_ready",  32'(in_ready),  32'd1);
        chk("rst.mant",      32'(out_mant),  32'd0);
        chk("rst.grs",       32'(out_grs),   32'd0);
        chk("rst.sign",      32'(out_sign),  32'd0);
        rst = 1'b0;

        do_op("v1", 24'hC00001, 8'd3, 1'b1, 24'h180000, 3'b001, 2);
        release_out("v1");
        do_op("v2", 24'h800003, 8'd2, 1'b0, 24'h200000, 3'b110, 2);
        release_out("v2");
        do_op("v3", 24'hFFFFFF, 8'd0, 1'b0, 24'hFFFFFF, 3'b000, 1);
        release_out("v3");
        do_op("v4", 24'hFFFFFF, 8'd8, 1'b1, 24'h00FFFF, 3'b111, 3);
        release_out("v4");
        do_op("sat40", 24'h000001, 8'd40, 1'b0, 24'h0, 3'b001, SAT_LAT);
        release_out("sat40");
        do_op("zero", 24'h000000, 8'd13, 1'b1, 24'h0, 3'b000, 5);
        release_out("zero");
        do_op("sh25", 24'h800000, 8'd25, 1'b0, 24'h0, 3'b010, 8);
        release_out("sh25");
        do_op("sh26", 24'h800000, 8'd26, 1'b0, 24'h0, 3'b001, SAT_LAT);
        release_out("sh26");
        do_op("sh1", 24'h000003, 8'd1, 1'b0, 24'h000001, 3'b100, 2);
        release_out("sh1");

        // Backpressure: hold DONE and pulse in_valid, which must be ignored.
        do_op("bp", 24'hC00001, 8'd3, 1'b1, 24'h180000, 3'b001, 2);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 2);
            in_mant  = 24'h123456;
            in_shamt = 8'd0;
            in_sign  = 1'b0;
            @(posedge clk);
            #1;
            chk("bp.valid", 32'(out_valid), 32'd1);
            chk("bp.ready", 32'(in_ready),  32'd0);
            chk("bp.mant",  32'(out_mant),  32'h180000);
            chk("bp.grs",   32'(out_grs),   32'b001);
            chk("bp.sign",  32'(out_sign),  32'd1);
        end
        in_valid = 1'b0;
        release_out("bp");
        @(posedge clk);
        #1;
        chk("bp.idle_valid", 32'(out_valid), 32'd0);

        // Reset during the third SHIFT cycle of a 20-bit shift.
        @(negedge clk);
        in_valid = 1'b1;
        in_mant  = 24'hABCDEF;
        in_shamt = 8'd20;
        in_sign  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("mid.ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid.valid", 32'(out_valid), 32'd0);
        chk("mid.in_ready", 32'(in_ready), 32'd1);
        chk("mid.mant",  32'(out_mant),  32'd0);
        chk("mid.grs",   32'(out_grs),   32'd0);
        chk("mid.sign",  32'(out_sign),  32'd0);
        do_op("post", 24'hC00001, 8'd3, 1'b1, 24'h180000, 3'b001, 2);

        // Reset while a result is held in DONE.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("hold.valid", 32'(out_valid), 32'd0);
        chk("hold.grs",   32'(out_grs),   32'd0);
        chk("hold.ready", 32'(in_ready),  32'd1);
        do_op("post2", 24'h800003, 8'd2, 1'b0, 24'h200000, 3'b110, 2);
        release_out("post2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
